// File: rtl/axis_ctrl_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the AXIS-Ctrl arbiter.
// The same rr_next() is used by the RTL and by the reference model in the bench.
package PkgAxisCtrlArb;

    localparam int AXIS_CTRL_WIDTH = 32;
    localparam int MAX_PORTS       = 16;
    localparam int MAX_IDX_W       = 4;

    typedef enum logic [0:0] {
        S_ARB,
        S_PASS
    } arb_state_e;

    // Scans ptr+1, ptr+2, ... modulo num_ports and returns the first requester.
    // With no request the pointer itself comes back, so callers gate on |req.
    function automatic logic [MAX_IDX_W-1:0] rr_next(
        input logic [MAX_PORTS-1:0] req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   num_ports
    );
        logic [MAX_IDX_W-1:0] winner;
        logic [MAX_IDX_W-1:0] idx_b;
        logic                 found;
        int                   idx;
        winner = ptr;
        found  = 1'b0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            idx   = (int'(ptr) + k) % num_ports;
            idx_b = MAX_IDX_W'(idx);
            if (!found && (k <= num_ports) && req[idx_b]) begin
                winner = idx_b;
                found  = 1'b1;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/axis_ctrl_rr_arbiter_skid.sv
// Two-entry skid register: output driven straight from flops, and in_ready_o
// depends only on occupancy so no combinational ready path crosses it.
module axis_ctrl_skid_reg #(
    parameter int DW = 33
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_ready_i,
    output logic [1:0]    occupancy_o
);

    logic          out_valid_q, skid_valid_q;
    logic [DW-1:0] out_data_q, skid_data_q;
    logic          push, pop;

    assign in_ready_o  = !skid_valid_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_q && out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign occupancy_o = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
        end else if (pop) begin
            // A full skid blocks push, so draining it never races an incoming beat.
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
            end else if (push) begin
                out_data_q <= in_data_i;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q) begin
                out_data_q  <= in_data_i;
                out_valid_q <= 1'b1;
            end else begin
                skid_data_q  <= in_data_i;
                skid_valid_q <= 1'b1;
            end
        end
    end

    // NOTE: skid_data_q is never observed while skid_valid_q is low, so it is
    // left out of reset; out_data_q is reset because it drives a visible port.

endmodule

// File: rtl/axis_ctrl_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS AXIS-Ctrl streams onto one master.
// One arbitration cycle between packets; a 2-entry skid register isolates the output.
module axis_ctrl_rr_arbiter
    import PkgAxisCtrlArb::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = AXIS_CTRL_WIDTH
) (
    input  logic                         ctrl_clk,
    input  logic                         ctrl_rst,
    input  logic [NUM_PORTS*WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS-1:0]         s_axis_tlast,
    input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
    output logic [NUM_PORTS-1:0]         s_axis_tready,
    output logic [WIDTH-1:0]             m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     prio_ptr_q, prio_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [MAX_PORTS-1:0] req_ext;
    logic [MAX_IDX_W-1:0] rr_winner;
    logic [WIDTH-1:0]     lane_data [NUM_PORTS];
    logic                 out_ready;
    logic                 pass_valid;
    logic [WIDTH:0]       skid_out;
    logic [1:0]           skid_occ;

    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_PORTS-1:0]   = s_axis_tvalid;
        rr_winner                = rr_next(req_ext, MAX_IDX_W'(prio_ptr_q), NUM_PORTS);
        for (int i = 0; i < NUM_PORTS; i++) begin
            lane_data[i] = s_axis_tdata[i*WIDTH +: WIDTH];
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        prio_ptr_d    = prio_ptr_q;
        grant_d       = grant_q;
        s_axis_tready = '0;
        pass_valid    = 1'b0;
        unique case (state_q)
            S_ARB: begin
                if (|s_axis_tvalid) begin
                    grant_d = IDX_W'(rr_winner);
                    state_d = S_PASS;
                end
            end
            S_PASS: begin
                s_axis_tready[grant_q] = out_ready;
                pass_valid             = s_axis_tvalid[grant_q];
                if (pass_valid && out_ready && s_axis_tlast[grant_q]) begin
                    prio_ptr_d = grant_q;
                    state_d    = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    always_ff @(posedge ctrl_clk) begin
        if (ctrl_rst) begin
            state_q    <= S_ARB;
            prio_ptr_q <= IDX_W'(NUM_PORTS - 1);
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            grant_q    <= grant_d;
        end
    end

    axis_ctrl_skid_reg #(
        .DW(WIDTH + 1)
    ) u_skid (
        .clk_i       (ctrl_clk),
        .rst_i       (ctrl_rst),
        .in_valid_i  (pass_valid),
        .in_data_i   ({s_axis_tlast[grant_q], lane_data[grant_q]}),
        .in_ready_o  (out_ready),
        .out_valid_o (m_axis_tvalid),
        .out_data_o  (skid_out),
        .out_ready_i (m_axis_tready),
        .occupancy_o (skid_occ)
    );

    assign m_axis_tdata = skid_out[WIDTH-1:0];
    assign m_axis_tlast = skid_out[WIDTH];
    assign grant_idx    = grant_q;
    assign busy         = (state_q == S_PASS) || (skid_occ != 2'd0);

endmodule

// File: tb/tb_axis_ctrl_rr_arbiter.sv
// Directed bench for axis_ctrl_rr_arbiter: per-port source queues, an arbitration
// model built on rr_next(), and an in-order scoreboard on the master port.
module tb_axis_ctrl_rr_arbiter;
    import PkgAxisCtrlArb::*;

    localparam int NP = 4;
    localparam int W  = 32;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    logic            ctrl_clk = 1'b0;
    logic            ctrl_rst;
    logic [NP*W-1:0] s_axis_tdata;
    logic [NP-1:0]   s_axis_tlast;
    logic [NP-1:0]   s_axis_tvalid;
    logic [NP-1:0]   s_axis_tready;
    logic [W-1:0]    m_axis_tdata;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [1:0]      grant_idx;
    logic            busy;

    always #5 ctrl_clk = ~ctrl_clk;

    axis_ctrl_rr_arbiter #(.NUM_PORTS(NP), .WIDTH(W)) dut (
        .ctrl_clk      (ctrl_clk),
        .ctrl_rst      (ctrl_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant_idx     (grant_idx),
        .busy          (busy)
    );

    beat_t src_q [NP][$];
    beat_t exp_out[$];
    int    out_ports[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   in_stall, out_stall, hold, hold_accepts;
    int   rst_run, post_rst, first_out_cyc, last_tlast_cyc, idle_cnt, in_beats, out_beats;
    logic rst_req, m_arb, out_in_pkt, out_started;
    logic [1:0] m_ptr, m_gnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input int port, input logic [W-1:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[port].push_back(b);
    endtask

    task automatic add_pkt(input int port, input int len, input int pkt);
        for (int w = 0; w < len; w++)
            push_word(port, {8'(port), 8'(pkt), 16'(w)}, w == len - 1);
    endtask

    function automatic int port_at(input int k);
        return (k < out_ports.size()) ? out_ports[k] : -1;
    endfunction

    function automatic logic all_done();
        logic d;
        d = (exp_out.size() == 0);
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() != 0) d = 1'b0;
        return d;
    endfunction

    // One clock: drive at negedge, observe settled handshakes just after.
    task automatic cycle();
        logic [NP-1:0]        fire;
        logic [MAX_PORTS-1:0] req;
        logic [MAX_IDX_W-1:0] win;
        beat_t                e;
        @(negedge ctrl_clk);
        ctrl_rst = rst_req;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && int'($urandom_range(99)) >= in_stall) begin
                s_axis_tvalid[p]       = 1'b1;
                s_axis_tdata[p*W +: W] = src_q[p][0].data;
                s_axis_tlast[p]        = src_q[p][0].last;
            end else begin
                s_axis_tvalid[p]       = 1'b0;
                s_axis_tdata[p*W +: W] = '0;
                s_axis_tlast[p]        = 1'b0;
            end
        end
        if (hold > 0) m_axis_tready = 1'b0;
        else          m_axis_tready = (int'($urandom_range(99)) >= out_stall);
        #1;
        if (ctrl_rst) begin
            if (rst_run > 0) begin
                check("rst_s_tready", s_axis_tready, 0);
                check("rst_m_tvalid", m_axis_tvalid, 0);
                check("rst_m_tdata", m_axis_tdata, 0);
                check("rst_m_tlast", m_axis_tlast, 0);
                check("rst_busy", busy, 0);
                check("rst_grant_idx", grant_idx, 0);
            end
            rst_run++;
            post_rst      = 0;
            first_out_cyc = -1;
            m_arb         = 1'b1;
            m_ptr         = 2'(NP - 1);
            out_in_pkt    = 1'b0;
            exp_out.delete();
        end else begin
            rst_run = 0;
            fire    = s_axis_tvalid & s_axis_tready;
            if (m_arb) begin
                check("arb_s_tready", s_axis_tready, 0);
                if (|s_axis_tvalid) begin
                    req          = '0;
                    req[NP-1:0]  = s_axis_tvalid;
                    win          = rr_next(req, 4'(m_ptr), NP);
                    m_gnt        = win[1:0];
                    m_arb        = 1'b0;
                end
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (fire[p]) begin
                        check("src_port", p, m_gnt);
                        e = src_q[p].pop_front();
                        exp_out.push_back(e);
                        in_beats++;
                        if (hold > 0) hold_accepts++;
                        if (e.last) begin
                            m_ptr = m_gnt;
                            m_arb = 1'b1;
                        end
                    end
                end
            end
            if (m_axis_tvalid) begin
                if (first_out_cyc < 0) first_out_cyc = post_rst;
                out_started = 1'b1;
            end else if (out_started && !all_done()) begin
                idle_cnt++;
            end
            if (hold > 0) begin
                check("bp_m_tvalid", m_axis_tvalid, 1);
                check("bp_m_tdata", m_axis_tdata, (exp_out.size() > 0) ? exp_out[0].data : 32'hdead_beef);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_beats++;
                check("out_expected", exp_out.size() > 0, 1);
                if (exp_out.size() > 0) begin
                    e = exp_out.pop_front();
                    check("out_data", m_axis_tdata, e.data);
                    check("out_last", m_axis_tlast, e.last);
                end
                if (!out_in_pkt) out_ports.push_back(int'(m_axis_tdata[31:24]));
                out_in_pkt = !m_axis_tlast;
                if (m_axis_tlast) last_tlast_cyc = post_rst;
            end
            post_rst++;
        end
        if (hold > 0) hold--;
    endtask

    task automatic do_reset(input int n);
        out_ports.delete();
        out_beats      = 0;
        in_beats       = 0;
        idle_cnt       = 0;
        out_started    = 1'b0;
        last_tlast_cyc = -1;
        rst_req        = 1'b1;
        repeat (n) cycle();
        rst_req = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && !all_done(); i++) cycle();
        check(tag, all_done(), 1);
        repeat (2) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_rst      = 1'b1;
        rst_req       = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        in_stall = 0; out_stall = 0; hold = 0; hold_accepts = 0;
        rst_run = 0; post_rst = 0; first_out_cyc = -1;
        m_arb = 1'b1; m_ptr = 2'(NP - 1); m_gnt = '0; out_in_pkt = 1'b0;

        // Reset held 4 cycles with every port requesting; port 0 goes first.
        for (int p = 0; p < NP; p++) add_pkt(p, 2, 16);
        do_reset(4);
        drain("rst_drain", 200);
        check("rst_first_port", port_at(0), 0);
        check("rst_second_port", port_at(1), 1);
        check("rst_first_latency", first_out_cyc, 2);
        check("rst_pkt_count", out_ports.size(), 4);
        check("idle_busy", busy, 0);

        // Basic forward: 5 words from port 2 on cycles 2..6.
        do_reset(2);
        for (int w = 1; w <= 5; w++) push_word(2, 32'(w), w == 5);
        drain("fwd_drain", 100);
        check("fwd_first_cycle", first_out_cyc, 2);
        check("fwd_last_cycle", last_tlast_cyc, 6);
        check("fwd_beats", out_beats, 5);
        check("fwd_grant_idx", grant_idx, 2);
        check("fwd_busy", busy, 0);

        // Fairness: 40 three-word packets, strict 0,1,2,3 rotation, one bubble each.
        do_reset(2);
        for (int k = 0; k < 10; k++)
            for (int p = 0; p < NP; p++) add_pkt(p, 3, k);
        drain("rr_drain", 1000);
        check("rr_pkt_count", out_ports.size(), 40);
        for (int k = 0; k < 40; k++) check($sformatf("rr_order_%0d", k), port_at(k), k % NP);
        check("rr_idle_cycles", idle_cnt, 39);

        // Atomicity under random stalls on both sides, ports 0 and 1.
        do_reset(2);
        in_stall  = 60;
        out_stall = 60;
        for (int k = 0; k < 8; k++) begin
            add_pkt(0, (k % 4) + 1, k);
            add_pkt(1, ((k + 2) % 4) + 1, k);
        end
        drain("stall_drain", 4000);
        check("stall_beats", out_beats, 40);
        check("stall_pkt_count", out_ports.size(), 16);
        in_stall  = 0;
        out_stall = 0;

        // Backpressure: master stalls 10 cycles mid-packet.
        do_reset(2);
        add_pkt(1, 8, 5);
        for (int i = 0; i < 50 && out_beats < 3; i++) cycle();
        check("bp_reach", out_beats, 3);
        hold         = 10;
        hold_accepts = 0;
        drain("bp_drain", 200);
        check("bp_extra_le2", hold_accepts <= 2, 1);
        check("bp_beats", out_beats, 8);

        // Reset after the 2nd upstream word of a 4-word packet.
        do_reset(2);
        add_pkt(2, 4, 7);
        for (int i = 0; i < 50 && in_beats < 2; i++) cycle();
        check("mid_reach", in_beats, 2);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        do_reset(2);
        add_pkt(1, 2, 8);
        add_pkt(0, 2, 8);
        drain("mid_drain", 200);
        check("mid_first_port", port_at(0), 0);
        check("mid_second_port", port_at(1), 1);
        check("mid_first_latency", first_out_cyc, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_ctrl_rr_arbiter.md
Name: axis_ctrl_rr_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges NUM_PORTS AXIS-Ctrl request streams (32-bit words, tlast-delimited) onto one AXIS-Ctrl master port.
- Sits in the ctrl clock domain between block control masters and the shared AXIS-Ctrl crossbar port, so several requesters can share one control endpoint.
- Format-agnostic: forwards words unmodified and never splits or interleaves a packet.

Parameters:
- NUM_PORTS, 4, number of slave inputs; legal range 2..16.
- WIDTH, 32, AXIS-Ctrl word width; fixed at 32 in the package, exposed for bench symmetry.

Ports:
- ctrl_clk  in  1  control clock; all logic on its rising edge.
- ctrl_rst  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  NUM_PORTS*WIDTH  per-port data; port i occupies bits [i*WIDTH +: WIDTH].
- s_axis_tlast  in  NUM_PORTS  per-port end-of-packet.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  WIDTH  merged data.
- m_axis_tlast  out  1  merged end-of-packet.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- grant_idx  out  $clog2(NUM_PORTS)  currently or last granted port (status only).
- busy  out  1  high while in S_PASS or while the output stage holds data.

Behaviour:
- Reset (ctrl_rst=1 sampled on an edge): state=S_ARB; prio_ptr=NUM_PORTS-1, so port 0 wins first; grant_idx=0; s_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; busy=0. Output stage contents are discarded. A reset asserted mid-packet drops the remainder; the bench re-sends.
- S_ARB:
  - s_axis_tready all 0.
  - If any tvalid is set, grant the first requester scanning prio_ptr+1, prio_ptr+2, ... modulo NUM_PORTS.
  - Register the winner in grant_idx and move to S_PASS on the next edge.
  - With no requests, stay in S_ARB.
- S_PASS:
  - s_axis_tready[grant_idx] = out_ready (the output stage can accept); every other port's ready is 0.
  - A beat transfers when tvalid & tready of the granted port.
  - On a transfer with tlast=1: prio_ptr <= grant_idx, then return to S_ARB.
  - Requests from other ports are ignored until tlast; tvalid deasserting mid-packet just stalls.
- Arbitration bubble: exactly one cycle in S_ARB between packets. Back-to-back single-word packets therefore achieve at most 50% throughput.
- Latency: tvalid rising in cycle 0 (S_ARB) -> tready in cycle 1 -> first word on m_axis in cycle 2, given m_axis_tready=1.
- Output stage: 2-entry skid register.
  - Full throughput within a packet.
  - out_ready depends only on registered occupancy (no combinational m_axis_tready -> s_axis_tready path).
  - m_axis_tvalid/tdata/tlast are driven straight from registers.
  - AXIS rules: once m_axis_tvalid=1, tdata/tlast hold until accepted; no beat is ever dropped or duplicated.
- Simultaneous events: a tlast beat on one port plus a new request from the next port in the same cycle gives S_ARB on the following cycle, and the new request wins by rotation.
- Only one requester active: it regains the grant after each one-cycle bubble. No starvation; worst-case wait is NUM_PORTS-1 packets.
- busy = (state==S_PASS) | (skid occupancy != 0).

Decomposition:
- Shared package PkgAxisCtrlArb: AXIS_CTRL_WIDTH=32; state enum {S_ARB, S_PASS}; function rr_next(req, ptr) returning the winner index. The same function is reused by the bench's reference model.
- One sub-module: axis_ctrl_skid_reg (WIDTH+1-bit 2-entry skid buffer with in/out valid-ready).
- The arbiter FSM lives in the top module. Estimated 150-250 RTL lines.

Test Plan:
- Reset: hold ctrl_rst 4 cycles with all tvalid=1 -> s_axis_tready=0 and m_axis_tvalid=0 throughout. The first packet granted after release comes from port 0, first word on m_axis 2 cycles after reset deasserts.
- Basic forward: port 2 sends a 5-word packet {0x1,2,3,4,5} (tlast on 5), m_axis_tready=1 -> identical 5 words on m_axis in cycles 2..6, tlast only on 0x5, grant_idx=2.
- Round-robin fairness: all 4 ports continuously send 3-word packets tagged with the port id -> m_axis packet order is 0,1,2,3,0,1,... for 40 packets; no interleaving within a packet; one idle cycle between packets.
- Atomicity under stalls: ports 0 and 1 request together, 60% random stall on s_axis_tvalid and on m_axis_tready -> each output packet is contiguous; bench model using rr_next matches order and data exactly.
- Backpressure: m_axis_tready=0 for 10 cycles mid-packet -> m_axis_tdata stable, at most 2 extra words accepted upstream; resume yields no loss or duplication.
- Reset mid-packet: assert ctrl_rst after the 2nd of 4 words -> outputs return to reset values next cycle; the following packet starts cleanly from port 0 priority.
